rca_seq_ctrl: RTL

Multi-precision add sequencer that time-shares one WIDTH-bit ripple-carry adder (rcA) to add NWORDS×WIDTH-bit operands. It processes one WIDTH-bit slice per cycle, LSB slice first, and feeds the carry of each slice back into the next. The adder sits outside this block and connects through the add_* ports. A start/busy/done handshake connects the block to the requesting logic.

---
 rtl/rca_seq_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-precision add sequencer that time-shares one external
// WIDTH-bit ripple-carry adder, processing one slice per cycle from the LSB
// slice upwards and feeding each slice's carry-out into the next slice.
// Optional build macro: RCA_SEQ_SUB_EN adds a 'sub' input that turns the
// operation into op_a - op_b (two's complement, cout=1 means no borrow).
module rca_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH*NWORDS-1:0] op_a,
    input  logic [WIDTH*NWORDS-1:0] op_b,
    input  logic                    cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH*NWORDS-1:0] sum,
    output logic                    cout,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_cin,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout
);

    localparam int TW = WIDTH * NWORDS;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [TW-1:0] a_reg;
    logic [TW-1:0] b_reg;
    logic [IW-1:0] idx;
    logic          carry;
    logic [TW-1:0] b_load;
    logic          c_load;

    // Choose the B operand and initial carry that get latched on an accepted start
    always_comb begin
        b_load = op_b;
        c_load = cin;
`ifdef RCA_SEQ_SUB_EN
        if (sub) begin
            b_load = ~op_b;
            c_load = 1'b1;
        end
`endif
    end

    // Sequencer: latch operands, walk the slices through the adder, then pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= b_load;
                        carry <= c_load;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(idx)*WIDTH +: WIDTH] <= add_sum;
                    carry <= add_cout;
                    if (idx == LAST_IDX) begin
                        cout  <= add_cout;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Present the current slice to the external adder only while running
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[int'(idx)*WIDTH +: WIDTH];
            add_b   = b_reg[int'(idx)*WIDTH +: WIDTH];
            add_cin = carry;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
